// File: rtl/omok_pkg.sv
// Shared constants, encodings and direction table for the omok game sequencer.
package omok_pkg;

  localparam int unsigned MAP_N      = 10;
  localparam int unsigned WIN_LEN    = 5;
  localparam int unsigned CELLS      = MAP_N * MAP_N;
  localparam int unsigned HIST_DEPTH = CELLS;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned POS_W      = 8;
  localparam int unsigned RC_W       = 5;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } colour_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_BLACK = 2'b01,
    WIN_WHITE = 2'b10
  } winner_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLACE,
    S_SCAN,
    S_DONE,
    S_UNDO
  } state_t;

  // One line direction as (drow, dcol)
  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } delta_t;

  // Direction table: 0 horizontal, 1 vertical, 2 main diagonal, 3 anti-diagonal
  function automatic delta_t dir_delta(input logic [1:0] dir);
    delta_t d;
    case (dir)
      2'd0:    begin d.dr = 2'sd0; d.dc = 2'sd1;  end
      2'd1:    begin d.dr = 2'sd1; d.dc = 2'sd0;  end
      2'd2:    begin d.dr = 2'sd1; d.dc = 2'sd1;  end
      default: begin d.dr = 2'sd1; d.dc = -2'sd1; end
    endcase
    return d;
  endfunction

  // Winner code for the colour that completed a line
  function automatic winner_t winner_code(input colour_t c);
    return (c == WHITE) ? WIN_WHITE : WIN_BLACK;
  endfunction

endpackage

// File: rtl/turn_controller_move_stack.sv
// LIFO of placed cell indices used to take moves back; count doubles as move_count.
module move_stack
  import omok_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [IDX_W-1:0] din,
  output logic [IDX_W-1:0] top,
  output logic             empty,
  output logic [IDX_W-1:0] count
);

  logic [IDX_W-1:0] mem [HIST_DEPTH];
  logic [IDX_W-1:0] ptr;
  logic             full;

  assign full  = (ptr == IDX_W'(HIST_DEPTH));
  assign empty = (ptr == '0);
  assign count = ptr;
  assign top   = empty ? '0 : mem[ptr - IDX_W'(1)];

  // Stack pointer; clear has priority so a new game empties the history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + IDX_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - IDX_W'(1);
    end
  end

  // Entry storage; contents above the pointer are don't-care
  always_ff @(posedge clk) begin
    if (push && !clear && !full) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Game sequencer: accepts place/undo/new-game, alternates turns and detects five in a row.
module turn_controller
  import omok_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] cur_pos,
  input  logic             put,
  input  logic             undo,
  input  logic             new_game,
  output logic [CELLS-1:0] black_board,
  output logic [CELLS-1:0] white_board,
  output logic             turn,
  output logic             busy,
  output logic             reject,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [IDX_W-1:0] move_count
);

  localparam logic signed [RC_W-1:0] MAX_RC = RC_W'(MAP_N - 1);

  state_t                 state;
  logic [POS_W-1:0]       pos_q;
  logic [1:0]             dir;
  logic                   side;
  logic [2:0]             step;
  logic [3:0]             count;
  logic signed [RC_W-1:0] cur_r, cur_c;
  logic                   put_s, put_d, undo_s, undo_d, ng_s, ng_d;

  logic                   put_edge, undo_edge, ng_edge;
  logic                   stk_push, stk_pop, stk_clear, stk_empty;
  logic [IDX_W-1:0]       stk_top;
  logic signed [RC_W-1:0] pos_row, pos_col, step_r, step_c, nr, nc;
  logic [IDX_W-1:0]       idx;
  logic [CELLS-1:0]       mover_board;
  logic                   in_bounds, hit, walk_on;
  logic [3:0]             count_n;
  delta_t                 d;

  assign put_edge  = put_s & ~put_d;
  assign undo_edge = undo_s & ~undo_d;
  assign ng_edge   = ng_s & ~ng_d;

  assign stk_push  = (state == S_PLACE);
  assign stk_pop   = (state == S_UNDO) && !stk_empty;
  assign stk_clear = (state == S_IDLE) && ng_edge;

  move_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (stk_clear),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pos_q[IDX_W-1:0]),
    .top   (stk_top),
    .empty (stk_empty),
    .count (move_count)
  );

  // Next cell along the current direction/side and whether it extends the mover's line
  always_comb begin
    pos_row     = $signed(RC_W'(pos_q / POS_W'(MAP_N)));
    pos_col     = $signed(RC_W'(pos_q % POS_W'(MAP_N)));
    d           = dir_delta(dir);
    step_r      = side ? -RC_W'($signed(d.dr)) : RC_W'($signed(d.dr));
    step_c      = side ? -RC_W'($signed(d.dc)) : RC_W'($signed(d.dc));
    nr          = cur_r + step_r;
    nc          = cur_c + step_c;
    in_bounds   = (nr >= 5'sd0) && (nr <= MAX_RC) && (nc >= 5'sd0) && (nc <= MAX_RC);
    idx         = IDX_W'(nr) * IDX_W'(MAP_N) + IDX_W'(nc);
    mover_board = turn ? white_board : black_board;
    hit         = in_bounds && mover_board[idx];
    count_n     = count + 4'(hit);
    walk_on     = hit && (step != 3'(WIN_LEN - 2));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pos_q       <= '0;
      dir         <= '0;
      side        <= 1'b0;
      step        <= '0;
      count       <= '0;
      cur_r       <= '0;
      cur_c       <= '0;
      put_s       <= 1'b0;
      put_d       <= 1'b0;
      undo_s      <= 1'b0;
      undo_d      <= 1'b0;
      ng_s        <= 1'b0;
      ng_d        <= 1'b0;
      black_board <= '0;
      white_board <= '0;
      turn        <= BLACK;
      busy        <= 1'b0;
      reject      <= 1'b0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      put_s  <= put;
      put_d  <= put_s;
      undo_s <= undo;
      undo_d <= undo_s;
      ng_s   <= new_game;
      ng_d   <= ng_s;
      reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ng_edge) begin
            black_board <= '0;
            white_board <= '0;
            turn        <= BLACK;
            game_over   <= 1'b0;
            winner      <= WIN_NONE;
            put_s       <= 1'b0;
            put_d       <= 1'b0;
            undo_s      <= 1'b0;
            undo_d      <= 1'b0;
            ng_s        <= 1'b0;
            ng_d        <= 1'b0;
          end else if (undo_edge) begin
            state <= S_UNDO;
            busy  <= 1'b1;
          end else if (put_edge) begin
            pos_q <= cur_pos;
            state <= S_CHECK;
            busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (game_over || (pos_q >= POS_W'(CELLS)) ||
              black_board[pos_q[IDX_W-1:0]] || white_board[pos_q[IDX_W-1:0]]) begin
            reject <= 1'b1;
            state  <= S_IDLE;
            busy   <= 1'b0;
          end else begin
            state <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (turn) white_board[pos_q[IDX_W-1:0]] <= 1'b1;
          else      black_board[pos_q[IDX_W-1:0]] <= 1'b1;
          cur_r <= pos_row;
          cur_c <= pos_col;
          dir   <= '0;
          side  <= 1'b0;
          step  <= '0;
          count <= 4'd1;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (walk_on) begin
            count <= count_n;
            cur_r <= nr;
            cur_c <= nc;
            step  <= step + 3'd1;
          end else if (!side) begin
            count <= count_n;
            side  <= 1'b1;
            step  <= '0;
            cur_r <= pos_row;
            cur_c <= pos_col;
          end else if (count_n >= 4'(WIN_LEN)) begin
            game_over <= 1'b1;
            winner    <= winner_code(colour_t'(turn));
            state     <= S_DONE;
          end else if (dir == 2'd3) begin
            state <= S_DONE;
          end else begin
            dir   <= dir + 2'd1;
            side  <= 1'b0;
            step  <= '0;
            count <= 4'd1;
            cur_r <= pos_row;
            cur_c <= pos_col;
          end
        end
        S_DONE: begin
          if (!game_over) turn <= ~turn;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_UNDO: begin
          if (stk_empty) begin
            reject <= 1'b1;
          end else begin
            black_board[stk_top] <= 1'b0;
            white_board[stk_top] <= 1'b0;
            turn                 <= ~turn;
            game_over            <= 1'b0;
            winner               <= WIN_NONE;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: cell-level game model plus directed move sequences.
module tb_turn_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cur_pos;
  logic        put, undo, new_game;
  logic [99:0] black_board, white_board;
  logic        turn, busy, reject, game_over;
  logic [1:0]  winner;
  logic [6:0]  move_count;

  turn_controller dut (
    .clk         (clk),
    .rst         (rst),
    .cur_pos     (cur_pos),
    .put         (put),
    .undo        (undo),
    .new_game    (new_game),
    .black_board (black_board),
    .white_board (white_board),
    .turn        (turn),
    .busy        (busy),
    .reject      (reject),
    .game_over   (game_over),
    .winner      (winner),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;

  // Model: cell contents 0 empty, 1 black, 2 white
  int       m_cell [100];
  int       m_hist [$];
  bit       m_turn, m_over;
  bit [1:0] m_winner;
  int       rej_exp, rej_seen;
  bit       model_valid, prev_rej;
  int       n_pass, n_total, last_bc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [99:0] pack(input int c);
    logic [99:0] v;
    v = '0;
    for (int i = 0; i < 100; i++) if (m_cell[i] == c) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit m_wins(input int p, input int c);
    int dr [4];
    int dc [4];
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int cnt;
      cnt = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int r, q;
        r = p / 10;
        q = p % 10;
        for (int k = 1; k < 5; k++) begin
          r += s * dr[d];
          q += s * dc[d];
          if (r < 0 || r > 9 || q < 0 || q > 9) break;
          if (m_cell[r*10+q] != c) break;
          cnt++;
        end
      end
      if (cnt >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_new();
    for (int i = 0; i < 100; i++) m_cell[i] = 0;
    m_hist.delete();
    m_turn = 0; m_over = 0; m_winner = 2'b00;
  endtask

  task automatic m_put(input int p);
    int c;
    if (m_over || p >= 100 || m_cell[p] != 0) begin
      rej_exp++;
    end else begin
      c = m_turn ? 2 : 1;
      m_cell[p] = c;
      m_hist.push_back(p);
      if (m_wins(p, c)) begin
        m_over = 1;
        m_winner = m_turn ? 2'b10 : 2'b01;
      end else begin
        m_turn = ~m_turn;
      end
    end
  endtask

  task automatic m_undo();
    int p;
    if (m_hist.size() == 0) begin
      rej_exp++;
    end else begin
      p = m_hist.pop_back();
      m_cell[p] = 0;
      m_turn = ~m_turn;
      m_over = 0;
      m_winner = 2'b00;
    end
  endtask

  // Continuous comparison against the model whenever the controller is idle
  always @(negedge clk) begin
    if (reject) begin
      rej_seen++;
      chk("reject_single_cycle", prev_rej, 1'b0);
    end
    prev_rej = reject;
    if (model_valid && rst) begin
      chk("black_board", black_board, pack(1));
      chk("white_board", white_board, pack(2));
      chk("turn", turn, m_turn);
      chk("move_count", move_count, m_hist.size());
      chk("game_over", game_over, m_over);
      chk("winner", winner, m_winner);
      chk("busy_idle", busy, 1'b0);
      chk("reject_idle", reject, 1'b0);
      chk("reject_count", rej_seen, rej_exp);
    end
  end

  // Press a button combination for one cycle, wait for completion, then update the model
  task automatic press(input bit p, input bit u, input bit n, input int pos);
    int bc;
    model_valid = 0;
    @(negedge clk);
    put = p; undo = u; new_game = n; cur_pos = 8'(pos);
    @(negedge clk);
    put = 0; undo = 0; new_game = 0;
    @(negedge clk);
    bc = 0;
    while (busy && bc < 60) begin
      @(negedge clk);
      bc++;
    end
    chk("op_completes", busy, 1'b0);
    last_bc = bc;
    @(negedge clk);
    if (n) m_new();
    else if (u) m_undo();
    else if (p) m_put(pos);
    model_valid = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic put_at(input int pos);
    press(1, 0, 0, pos);
  endtask

  task automatic do_undo();
    press(0, 1, 0, 0);
  endtask

  task automatic do_new();
    press(0, 0, 1, 0);
  endtask

  task automatic put_seq(input int seq [9]);
    for (int i = 0; i < 9; i++) put_at(seq[i]);
  endtask

  initial begin
    int bc;
    int row_seq [9];
    int wrap_seq [9];
    int diag_seq [9];
    logic [99:0] one;
    row_seq  = '{0, 10, 1, 11, 2, 12, 3, 13, 4};
    wrap_seq = '{8, 50, 9, 52, 10, 54, 11, 56, 12};
    diag_seq = '{0, 1, 11, 2, 22, 3, 33, 5, 44};
    one = 100'd1;
    n_pass = 0; n_total = 0; rej_exp = 0; rej_seen = 0; prev_rej = 0;
    model_valid = 0;
    rst = 0; put = 0; undo = 0; new_game = 0; cur_pos = '0;
    m_new();
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_black", black_board, 100'd0);
    chk("rst_white", white_board, 100'd0);
    chk("rst_turn", turn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_reject", reject, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_count", move_count, 7'd0);
    model_valid = 1;

    // First stone and illegal re-placement
    put_at(44);
    chk("p44_bit", black_board[44], 1'b1);
    chk("p44_turn", turn, 1'b1);
    chk("p44_count", move_count, 7'd1);
    chk("p44_over", game_over, 1'b0);
    put_at(44);
    chk("dup_rejects", rej_seen, 1);
    chk("dup_black", black_board, one << 44);
    chk("dup_white", white_board, 100'd0);
    chk("dup_turn", turn, 1'b1);

    // Horizontal win, then a put after game over
    do_new();
    put_seq(row_seq);
    chk("row_over", game_over, 1'b1);
    chk("row_winner", winner, 2'b01);
    chk("row_count", move_count, 7'd9);
    put_at(50);
    chk("over_put_rejects", rej_seen, 2);

    // Row-wrap stones must not count as a line
    do_new();
    put_seq(wrap_seq);
    chk("wrap_over", game_over, 1'b0);
    chk("wrap_winner", winner, 2'b00);
    chk("wrap_turn", turn, 1'b1);

    // Diagonal win within the scan latency bound, then take it back
    do_new();
    put_seq(diag_seq);
    chk("diag_winner", winner, 2'b01);
    chk("diag_latency_ok", last_bc <= 35, 1'b1);
    do_undo();
    chk("undo_win_over", game_over, 1'b0);
    chk("undo_win_winner", winner, 2'b00);
    chk("undo_win_bit", black_board[44], 1'b0);
    chk("undo_win_turn", turn, 1'b1);
    chk("undo_win_count", move_count, 7'd8);

    // Undo after three moves, then drain and undo on empty
    do_new();
    put_at(44); put_at(45); put_at(46);
    do_undo();
    chk("undo_bit46", black_board[46], 1'b0);
    chk("undo_turn", turn, 1'b0);
    chk("undo_count", move_count, 7'd2);
    do_undo(); do_undo();
    do_undo();
    chk("empty_undo_rejects", rej_seen, 3);

    // Request priority: new_game over put, undo over put
    put_at(20);
    press(1, 0, 1, 7);
    chk("ng_put_black", black_board, 100'd0);
    chk("ng_put_count", move_count, 7'd0);
    put_at(20);
    press(1, 1, 0, 7);
    chk("undo_put_black", black_board, 100'd0);
    chk("undo_put_turn", turn, 1'b0);

    // Out-of-range cursor positions
    put_at(100);
    put_at(255);
    chk("range_rejects", rej_seen, 5);

    // A put edge arriving while busy is dropped silently
    model_valid = 0;
    @(negedge clk); put = 1; cur_pos = 8'd60;
    @(negedge clk); put = 0;
    @(negedge clk);
    @(negedge clk); put = 1; cur_pos = 8'd61;
    @(negedge clk); put = 0;
    bc = 0;
    while (busy && bc < 60) begin
      @(negedge clk);
      bc++;
    end
    chk("drop_completes", busy, 1'b0);
    @(negedge clk);
    m_put(60);
    model_valid = 1;
    repeat (2) @(negedge clk);
    chk("drop_b60", black_board[60], 1'b1);
    chk("drop_b61", black_board[61], 1'b0);
    chk("drop_rejects", rej_seen, 5);

    // Asynchronous reset in the middle of a scan
    do_new();
    model_valid = 0;
    @(negedge clk); put = 1; cur_pos = 8'd55;
    @(negedge clk); put = 0;
    repeat (4) @(negedge clk);
    chk("scan_busy", busy, 1'b1);
    chk("scan_b55", black_board[55], 1'b1);
    #2 rst = 0;
    #1;
    chk("arst_black", black_board, 100'd0);
    chk("arst_white", white_board, 100'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_turn", turn, 1'b0);
    chk("arst_count", move_count, 7'd0);
    chk("arst_over", game_over, 1'b0);
    @(negedge clk);
    rst = 1;
    m_new();
    model_valid = 1;
    repeat (3) @(negedge clk);
    put_at(55);
    chk("post_rst_b55", black_board[55], 1'b1);

    model_valid = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
